// File: rtl/mdc_r2_stage.sv
// Radix-2 DIF stage for a two-lane multipath delay commutator FFT; chain with DEPTH = N/2 ... 1.
// Optional build macro MDC_STAGE_SAT_EN: saturate instead of wrap when narrowing outputs to WIDTH.
module mdc_r2_stage #(
  parameter int WIDTH    = 9,
  parameter int DEPTH    = 16,
  parameter int TW_WIDTH = 9
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    in_valid,
  input  logic                    scale,
  input  logic signed [WIDTH-1:0] in_up_re,
  input  logic signed [WIDTH-1:0] in_up_im,
  input  logic signed [WIDTH-1:0] in_lo_re,
  input  logic signed [WIDTH-1:0] in_lo_im,
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] out_up_re,
  output logic signed [WIDTH-1:0] out_up_im,
  output logic signed [WIDTH-1:0] out_lo_re,
  output logic signed [WIDTH-1:0] out_lo_im
);

  localparam int  CW = $clog2(2 * DEPTH);
  localparam int  KW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int  PW = WIDTH + TW_WIDTH + 1;
  localparam int  SH = TW_WIDTH - 2;
  localparam real PI = 3.14159265358979323846;

  // Taylor series keeps the ROM build independent of tool support for $sin/$cos.
  function automatic real sin_t(input real x);
    real term;
    real sum;
    term = x;
    sum  = x;
    for (int n = 1; n < 12; n++) begin
      term = -term * x * x / ((2.0 * n) * (2.0 * n + 1.0));
      sum  = sum + term;
    end
    return sum;
  endfunction

  function automatic real cos_t(input real x);
    real term;
    real sum;
    term = 1.0;
    sum  = 1.0;
    for (int n = 1; n < 12; n++) begin
      term = -term * x * x / ((2.0 * n - 1.0) * (2.0 * n));
      sum  = sum + term;
    end
    return sum;
  endfunction

  function automatic logic signed [TW_WIDTH-1:0] tw_coef(input int k, input bit im);
    real a;
    real v;
    int  r;
    a = PI * real'(k) / real'(DEPTH);
    v = im ? -sin_t(a) : cos_t(a);
    v = v * real'(1 << SH);
    r = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    return TW_WIDTH'(r);
  endfunction

  function automatic logic signed [WIDTH-1:0] narrow(input logic signed [PW-1:0] v);
`ifdef MDC_STAGE_SAT_EN
    logic signed [PW-1:0] vmax;
    logic signed [PW-1:0] vmin;
    vmax = PW'((1 << (WIDTH - 1)) - 1);
    vmin = -PW'(1 << (WIDTH - 1));
    if (v > vmax) return vmax[WIDTH-1:0];
    if (v < vmin) return vmin[WIDTH-1:0];
    return v[WIDTH-1:0];
`else
    return v[WIDTH-1:0];
`endif
  endfunction

  logic signed [TW_WIDTH-1:0] w_re_rom [DEPTH];
  logic signed [TW_WIDTH-1:0] w_im_rom [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    localparam logic signed [TW_WIDTH-1:0] WR = tw_coef(g, 1'b0);
    localparam logic signed [TW_WIDTH-1:0] WI = tw_coef(g, 1'b1);
    assign w_re_rom[g] = WR;
    assign w_im_rom[g] = WI;
  end

  logic [CW-1:0] cnt_q, cnt_d, cnt_eff;
  logic          filled_q, filled_d, filled_eff;
  logic          sel;
  logic [KW-1:0] k;

  logic signed [WIDTH-1:0] dl_re_q [DEPTH];
  logic signed [WIDTH-1:0] dl_im_q [DEPTH];

  logic signed [WIDTH-1:0] com_up_re, com_up_im, com_lo_re, com_lo_im;
  logic signed [WIDTH-1:0] d_re, d_im;
  logic signed [WIDTH:0]   s_re, s_im, t_re, t_im;
  logic signed [PW-1:0]    p_re, p_im, lo_re_f, lo_im_f, up_re_f, up_im_f;

  logic                    out_valid_q;
  logic signed [WIDTH-1:0] out_up_re_q, out_up_im_q, out_lo_re_q, out_lo_im_q;
  logic signed [WIDTH-1:0] out_up_re_d, out_up_im_d, out_lo_re_d, out_lo_im_d;

  // A clear on the same cycle as a sample makes that sample cnt=0 of the new frame.
  always_comb begin
    cnt_eff    = clear ? '0 : cnt_q;
    filled_eff = clear ? 1'b0 : filled_q;
    sel        = cnt_eff[CW-1];
    k          = KW'(cnt_eff & CW'(DEPTH - 1));
    cnt_d      = cnt_eff;
    filled_d   = filled_eff;
    if (in_valid) begin
      cnt_d    = cnt_eff + CW'(1);
      filled_d = filled_eff | (cnt_eff == CW'(DEPTH - 1));
    end
  end

  always_comb begin
    com_up_re = sel ? in_lo_re : in_up_re;
    com_up_im = sel ? in_lo_im : in_up_im;
    com_lo_re = sel ? in_up_re : in_lo_re;
    com_lo_im = sel ? in_up_im : in_lo_im;
    d_re      = dl_re_q[DEPTH-1];
    d_im      = dl_im_q[DEPTH-1];
    s_re      = (WIDTH+1)'(d_re) + (WIDTH+1)'(com_lo_re);
    s_im      = (WIDTH+1)'(d_im) + (WIDTH+1)'(com_lo_im);
    t_re      = (WIDTH+1)'(d_re) - (WIDTH+1)'(com_lo_re);
    t_im      = (WIDTH+1)'(d_im) - (WIDTH+1)'(com_lo_im);
    p_re      = PW'(t_re) * PW'(w_re_rom[k]) - PW'(t_im) * PW'(w_im_rom[k]);
    p_im      = PW'(t_re) * PW'(w_im_rom[k]) + PW'(t_im) * PW'(w_re_rom[k]);
    lo_re_f   = p_re >>> SH;
    lo_im_f   = p_im >>> SH;
    up_re_f   = PW'(s_re);
    up_im_f   = PW'(s_im);
    if (scale) begin
      lo_re_f = lo_re_f >>> 1;
      lo_im_f = lo_im_f >>> 1;
      up_re_f = up_re_f >>> 1;
      up_im_f = up_im_f >>> 1;
    end
    out_up_re_d = narrow(up_re_f);
    out_up_im_d = narrow(up_im_f);
    out_lo_re_d = narrow(lo_re_f);
    out_lo_im_d = narrow(lo_im_f);
  end

  // Streaming contract: in_valid marks a consumed sample (no backpressure); out_valid
  // marks a fresh output pair one clock later; data outputs hold while out_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      filled_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_up_re_q <= '0;
      out_up_im_q <= '0;
      out_lo_re_q <= '0;
      out_lo_im_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dl_re_q[i] <= '0;
        dl_im_q[i] <= '0;
      end
    end else begin
      cnt_q       <= cnt_d;
      filled_q    <= filled_d;
      out_valid_q <= in_valid && filled_eff;
      if (in_valid) begin
        for (int i = DEPTH - 1; i > 0; i--) begin
          dl_re_q[i] <= dl_re_q[i-1];
          dl_im_q[i] <= dl_im_q[i-1];
        end
        dl_re_q[0] <= com_up_re;
        dl_im_q[0] <= com_up_im;
      end
      if (in_valid && filled_eff) begin
        out_up_re_q <= out_up_re_d;
        out_up_im_q <= out_up_im_d;
        out_lo_re_q <= out_lo_re_d;
        out_lo_im_q <= out_lo_im_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_up_re = out_up_re_q;
  assign out_up_im = out_up_im_q;
  assign out_lo_re = out_lo_re_q;
  assign out_lo_im = out_lo_im_q;

endmodule
